ssm_memory_unit: RTL and testbench
==================================

// Module: ssm_memory_unit
//
// PURPOSE
// Word-addressed memory responder on the far side of the MAR/MDR memory interface. It
// accepts read/write requests from the CPU-side MDR and MAR, and inserts a configurable
// number of wait states. It completes each transfer with a 4-phase req/ready handshake:
// write data comes from the MDR's data_to_memory, and read data goes to the MDR's
// data_from_memory.
//
// PARAMETERS
// DATA_WIDTH   16   width of a memory word and of both data ports
// ADDR_WIDTH   8    width of MEM_addr
// DEPTH        200  number of implemented words; addresses >= DEPTH are out of range
// WAIT_STATES  2    extra cycles between request capture and access (0..15)
//
// PORTS
// MEM_clock          in   1           system clock, all state on rising edge
// MEM_reset_n        in   1           asynchronous, active-low reset
// MEM_req            in   1           request strobe from control unit, held until MEM_ready
// MEM_we             in   1           1 = write, 0 = read; sampled with MEM_req
// MEM_addr           in   ADDR_WIDTH  word address (from MAR); sampled with MEM_req
// MEM_data_from_mdr  in   DATA_WIDTH  write data (MDR data_to_memory); sampled with MEM_req
// MEM_data_to_mdr    out  DATA_WIDTH  read data (to MDR data_from_memory), registered
// MEM_ready          out  1           transfer complete; held high until MEM_req falls
// MEM_busy           out  1           high from capture until return to IDLE
// MEM_error          out  1           last transfer was out of range; valid while MEM_ready
//
// BEHAVIOUR
// - Reset (MEM_reset_n=0, async): state=IDLE, wait counter=0.
//   MEM_data_to_mdr=0, MEM_ready=0, MEM_busy=0, MEM_error=0.
//   Array contents are NOT cleared.
// - FSM states: IDLE, WAIT, ACCESS, DONE. All outputs are registered.
// - IDLE: when MEM_req=1 at an edge, capture MEM_we, MEM_addr and MEM_data_from_mdr.
//   Next state is WAIT (WAIT_STATES>0) or ACCESS (WAIT_STATES=0). Set MEM_busy=1 and
//   clear MEM_error.
// - WAIT: counter counts 0..WAIT_STATES-1, one step per cycle.
//   At count WAIT_STATES-1, go to ACCESS and reset the counter.
// - ACCESS, exactly one cycle:
//   - In range, write: mem[addr] <= wdata.
//   - In range, read: MEM_data_to_mdr <= mem[addr].
//   - Out of range: no array write, MEM_data_to_mdr <= 0, MEM_error <= 1.
//   - Then go to DONE and set MEM_ready <= 1.
// - DONE: hold MEM_ready=1 while MEM_req=1.
//   When MEM_req=0 at an edge: MEM_ready<=0, MEM_busy<=0, go to IDLE.
// - Latency: MEM_ready rises at the (WAIT_STATES+2)th rising edge after MEM_req is first
//   seen high in IDLE, counting that capture edge as the 1st (i.e. WAIT_STATES+1 edges
//   later). Example: WAIT_STATES=2 gives capture at edge 0 and ready after edge 3.
// - Captured request fields are frozen. Input changes after capture have no effect on
//   the current transfer.
// - Request hygiene: MEM_req must be seen low in DONE before a new request is accepted.
//   A req held high across DONE->IDLE is impossible by construction, so no double
//   transfer occurs.
// - MEM_data_to_mdr holds the last read value. Writes and IDLE do not change it.
//   An out-of-range read sets it to 0.
// - MEM_we is ignored outside capture. MEM_error persists through DONE and is cleared on
//   the next capture.
// - Reset mid-operation: the transfer is aborted and all outputs are reset.
//   A write aborted before ACCESS leaves the array unchanged.
//   A write already completed in ACCESS is retained.
//
// TESTING
// - Write/read-back: write 0xBEEF to addr 0x05, then read addr 0x05.
//   Expect MEM_data_to_mdr=0xBEEF with MEM_ready=1 and MEM_error=0.
// - Latency: WAIT_STATES=2, req captured at edge 0. Expect MEM_ready=0 through edge 2,
//   =1 after edge 3. With WAIT_STATES=0, expect ready after edge 1.
// - Out of range: read addr 0xC8 (DEPTH=200). Expect MEM_error=1 and MEM_data_to_mdr=0.
//   A write of 0x1234 to 0xC8 changes no location (verify 0x00..0xC7 unchanged).
// - Handshake: hold MEM_req high for 10 cycles after ready. Expect one transfer only and
//   MEM_ready held. Drop req: MEM_ready=0 and MEM_busy=0 on the next edge.
// - Frozen capture: issue a write to addr 0x10, then change MEM_addr to 0x20 in WAIT.
//   Expect mem[0x10] written and mem[0x20] untouched.
// - Async reset: assert MEM_reset_n low mid-edge during WAIT of a write to 0x30 (old value
//   0x0001). Expect outputs 0 immediately, state IDLE, mem[0x30]=0x0001.

Source files
------------

// File: rtl/ssm_memory_unit.sv
// Word-addressed memory responder behind the MAR/MDR interface.
// Each request is captured once and frozen. It then waits WAIT_STATES cycles and does
// one access cycle. The transfer closes with a 4-phase req/ready handshake.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for MEM_req; captures we/addr/data on the req edge
// ST_WAIT   | inserting WAIT_STATES wait cycles (wait_cnt 0..WAIT_STATES-1)
// ST_ACCESS | single array access cycle; raises MEM_ready
// ST_DONE   | holds MEM_ready until MEM_req is seen low, then back to idle
module ssm_memory_unit #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH       = 200,
   parameter int WAIT_STATES = 2
) (
   input  logic                  MEM_clock,
   input  logic                  MEM_reset_n,
   input  logic                  MEM_req,
   input  logic                  MEM_we,
   input  logic [ADDR_WIDTH-1:0] MEM_addr,
   input  logic [DATA_WIDTH-1:0] MEM_data_from_mdr,
   output logic [DATA_WIDTH-1:0] MEM_data_to_mdr,
   output logic                  MEM_ready,
   output logic                  MEM_busy,
   output logic                  MEM_error
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

   logic [1:0]            state;
   logic [3:0]            wait_cnt;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  in_range;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Range check is done on the frozen address, one bit wider so DEPTH fits.
   assign in_range = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(DEPTH));

   // Array write port: no reset, so contents survive MEM_reset_n.
   always_ff @(posedge MEM_clock) begin
      if (state == ST_ACCESS && we_q && in_range) begin
         mem[addr_q] <= wdata_q;
      end
   end

   // Sequencer: capture, wait-state count, access, and handshake outputs.
   always_ff @(posedge MEM_clock or negedge MEM_reset_n) begin
      if (!MEM_reset_n) begin
         state           <= ST_IDLE;
         wait_cnt        <= '0;
         we_q            <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         MEM_data_to_mdr <= '0;
         MEM_ready       <= 1'b0;
         MEM_busy        <= 1'b0;
         MEM_error       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (MEM_req) begin
                  we_q      <= MEM_we;
                  addr_q    <= MEM_addr;
                  wdata_q   <= MEM_data_from_mdr;
                  MEM_busy  <= 1'b1;
                  MEM_error <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  wait_cnt <= '0;
                  state    <= ST_ACCESS;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            ST_ACCESS: begin
               if (in_range) begin
                  if (!we_q) begin
                     MEM_data_to_mdr <= mem[addr_q];
                  end
               end else begin
                  MEM_data_to_mdr <= '0;
                  MEM_error       <= 1'b1;
               end
               MEM_ready <= 1'b1;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               if (!MEM_req) begin
                  MEM_ready <= 1'b0;
                  MEM_busy  <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ssm_memory_unit.sv
// Bench for ssm_memory_unit: directed vector table, corner-case sequences and
// random transfers against an array-based reference model.
module tb_ssm_memory_unit;

   localparam int WS    = 2;
   localparam int DEPTH = 200;

   logic        clk;
   logic        rst_n;
   logic        req, we;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ready, busy, error;

   logic        req0, we0;
   logic [7:0]  addr0;
   logic [15:0] wdata0;
   logic [15:0] rdata0;
   logic        ready0, busy0, error0;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [15:0] model [DEPTH];
   logic [15:0] last_rd;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic        chk_data;
      logic [15:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [10];

   ssm_memory_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
      .MEM_clock(clk), .MEM_reset_n(rst_n), .MEM_req(req), .MEM_we(we),
      .MEM_addr(addr), .MEM_data_from_mdr(wdata), .MEM_data_to_mdr(rdata),
      .MEM_ready(ready), .MEM_busy(busy), .MEM_error(error));

   ssm_memory_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
      .MEM_clock(clk), .MEM_reset_n(rst_n), .MEM_req(req0), .MEM_we(we0),
      .MEM_addr(addr0), .MEM_data_from_mdr(wdata0), .MEM_data_to_mdr(rdata0),
      .MEM_ready(ready0), .MEM_busy(busy0), .MEM_error(error0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Expected outcome of one transfer from the memory rules; updates the model.
   task automatic model_apply(input logic w, input logic [7:0] a, input logic [15:0] d,
                              output logic [15:0] ed, output logic ee);
      ee = (int'(a) >= DEPTH);
      if (ee) begin
         last_rd = 16'h0000;
      end else if (w) begin
         model[a] = d;
      end else begin
         last_rd = model[a];
      end
      ed = last_rd;
   endtask

   // One full transfer on the WS=2 instance; ready is held 'hold' extra cycles.
   task automatic xfer(input logic w, input logic [7:0] a, input logic [15:0] d,
                       input int hold, output logic [15:0] rd, output logic er);
      int lat;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) chk("busy_after_capture", busy, 1);
         if (ready) break;
      end
      chk("latency", lat, WS + 2);
      rd = rdata;
      er = error;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_ready", ready, 1);
         chk("hold_busy", busy, 1);
      end
      @(negedge clk);
      req = 1'b0; we = 1'($urandom); addr = 8'($urandom); wdata = 16'($urandom);
      @(posedge clk); #1;
      chk("drop_ready", ready, 0);
      chk("drop_busy", busy, 0);
   endtask

   task automatic txn(input logic w, input logic [7:0] a, input logic [15:0] d, input int hold);
      logic [15:0] rd, ed;
      logic er, ee;
      xfer(w, a, d, hold, rd, er);
      model_apply(w, a, d, ed, ee);
      chk("txn_data", rd, ed);
      chk("txn_err", er, ee);
   endtask

   task automatic full_mem_check();
      for (int i = 0; i < DEPTH; i++) txn(1'b0, 8'(i), 16'h0, 0);
   endtask

   initial begin
      logic [15:0] rd, ed, v;
      logic er, ee;
      int lat;

      vecs[0] = '{1'b1, 8'h05, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
      vecs[1] = '{1'b0, 8'h05, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
      vecs[2] = '{1'b0, 8'hC8, 16'h0000, 1'b1, 16'h0000, 1'b1};
      vecs[3] = '{1'b1, 8'hC8, 16'h1234, 1'b1, 16'h0000, 1'b1};
      vecs[4] = '{1'b0, 8'h05, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
      vecs[5] = '{1'b1, 8'hC7, 16'hA5A5, 1'b1, 16'hBEEF, 1'b0};
      vecs[6] = '{1'b0, 8'hC7, 16'h0000, 1'b1, 16'hA5A5, 1'b0};
      vecs[7] = '{1'b0, 8'hFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
      vecs[8] = '{1'b1, 8'h00, 16'h0001, 1'b1, 16'h0000, 1'b0};
      vecs[9] = '{1'b0, 8'h00, 16'h0000, 1'b1, 16'h0001, 1'b0};

      rst_n = 1'b0;
      req = 0; we = 0; addr = 0; wdata = 0;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      last_rd = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_data", rdata, 0);
      chk("reset_ready", ready, 0);
      chk("reset_busy", busy, 0);
      chk("reset_error", error, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Put known contents in every implemented word.
      for (int i = 0; i < DEPTH; i++) txn(1'b1, 8'(i), 16'($urandom), 0);

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, rd, er);
         model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata, ed, ee);
         if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
         chk($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      end

      // Out-of-range write must not have touched any implemented word.
      full_mem_check();

      // Handshake: ready held for 10 cycles; input changes in DONE cause no second write.
      xfer(1'b1, 8'h40, 16'h4444, 10, rd, er);
      model_apply(1'b1, 8'h40, 16'h4444, ed, ee);
      txn(1'b0, 8'h40, 16'h0, 0);

      // Frozen capture: address and data change while waiting.
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 8'h10; wdata = 16'h1010;
      @(posedge clk); #1;
      chk("frozen_busy", busy, 1);
      @(negedge clk);
      addr = 8'h20; wdata = 16'h2020; we = 1'b0;
      lat = 1;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (ready) break;
      end
      chk("frozen_latency", lat, WS + 2);
      @(negedge clk);
      req = 1'b0;
      @(posedge clk); #1;
      model_apply(1'b1, 8'h10, 16'h1010, ed, ee);
      txn(1'b0, 8'h10, 16'h0, 0);
      txn(1'b0, 8'h20, 16'h0, 0);

      // Async reset in WAIT of a write; old value must survive.
      txn(1'b1, 8'h30, 16'h0001, 0);
      txn(1'b0, 8'h05, 16'h0, 0);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 8'h30; wdata = 16'hFFFF;
      @(posedge clk); #1;
      chk("rst_busy_before", busy, 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_data", rdata, 0);
      chk("async_rst_ready", ready, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_error", error, 0);
      req = 1'b0;
      last_rd = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      txn(1'b0, 8'h30, 16'h0, 0);

      // Random transfers against the model.
      for (int i = 0; i < 300; i++) begin
         v = 16'($urandom);
         if ($urandom_range(0, 7) == 0)
            txn(1'($urandom), 8'($urandom_range(DEPTH, 255)), v, $urandom_range(0, 2));
         else
            txn(1'($urandom), 8'($urandom_range(0, DEPTH - 1)), v, $urandom_range(0, 2));
      end
      full_mem_check();

      // Zero-wait-state instance: ready after the edge following capture.
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         req0 = 1'b1; we0 = (t == 0); addr0 = 8'h03; wdata0 = 16'h5555;
         lat = 0;
         while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ready0) break;
         end
         chk("ws0_latency", lat, 2);
         chk("ws0_err", error0, 0);
         if (t == 1) chk("ws0_data", rdata0, 16'h5555);
         @(negedge clk);
         req0 = 1'b0;
         @(posedge clk); #1;
         chk("ws0_drop_ready", ready0, 0);
         chk("ws0_drop_busy", busy0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
